// File: rtl/ps2_kbd_pkg.sv
// Shared constants for the PS/2 keyboard to ZX matrix block: scancodes (set 2),
// half-row/bit positions, composite key indices, rx FSM states and the key map.
package ps2_kbd_pkg;

  localparam int ROWS = 8;
  localparam int COLS = 5;

  // Protocol bytes
  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_BAT   = 8'hAA;
  localparam logic [7:0] SC_OVR0  = 8'h00;
  localparam logic [7:0] SC_OVR1  = 8'hFF;

  // Keys with special handling
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_LCTRL  = 8'h14;
  localparam logic [7:0] SC_LALT   = 8'h11;
  localparam logic [7:0] SC_DEL    = 8'h71;  // E0-prefixed
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_ESC    = 8'h76;
  localparam logic [7:0] SC_LEFT   = 8'h6B;  // E0-prefixed
  localparam logic [7:0] SC_DOWN   = 8'h72;  // E0-prefixed
  localparam logic [7:0] SC_UP     = 8'h75;  // E0-prefixed
  localparam logic [7:0] SC_RIGHT  = 8'h74;  // E0-prefixed

  // Matrix positions used by the composite overlays
  localparam int ROW_CS    = 0;
  localparam int BIT_CS    = 0;
  localparam int ROW_SPACE = 7;
  localparam int BIT_SPACE = 0;
  localparam int ROW_1_5   = 3;  // 1 2 3 4 5
  localparam int ROW_0_6   = 4;  // 0 9 8 7 6
  localparam int BIT_K5    = 4;
  localparam int BIT_K0    = 0;
  localparam int BIT_K6    = 4;
  localparam int BIT_K7    = 3;
  localparam int BIT_K8    = 2;

  // Composite flag indices
  localparam int CMP_BKSP  = 0;
  localparam int CMP_ESC   = 1;
  localparam int CMP_LEFT  = 2;
  localparam int CMP_DOWN  = 3;
  localparam int CMP_UP    = 4;
  localparam int CMP_RIGHT = 5;
  localparam int NUM_CMP   = 6;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_e;

  typedef struct packed {
    logic       hit;
    logic [2:0] row;
    logic [2:0] col;
  } key_pos_t;

  function automatic key_pos_t kp(input int r, input int c);
    return {1'b1, 3'(r), 3'(c)};
  endfunction

  // Plain (non-E0) scancode to half-row/bit; hit=0 for unmapped codes.
  function automatic key_pos_t map_code(input logic [7:0] code);
    key_pos_t p;
    p = '0;
    case (code)
      8'h12: p = kp(0, 0);  // LShift -> CS
      8'h1A: p = kp(0, 1);  // Z
      8'h22: p = kp(0, 2);  // X
      8'h21: p = kp(0, 3);  // C
      8'h2A: p = kp(0, 4);  // V
      8'h1C: p = kp(1, 0);  // A
      8'h1B: p = kp(1, 1);  // S
      8'h23: p = kp(1, 2);  // D
      8'h2B: p = kp(1, 3);  // F
      8'h34: p = kp(1, 4);  // G
      8'h15: p = kp(2, 0);  // Q
      8'h1D: p = kp(2, 1);  // W
      8'h24: p = kp(2, 2);  // E
      8'h2D: p = kp(2, 3);  // R
      8'h2C: p = kp(2, 4);  // T
      8'h16: p = kp(3, 0);  // 1
      8'h1E: p = kp(3, 1);  // 2
      8'h26: p = kp(3, 2);  // 3
      8'h25: p = kp(3, 3);  // 4
      8'h2E: p = kp(3, 4);  // 5
      8'h45: p = kp(4, 0);  // 0
      8'h46: p = kp(4, 1);  // 9
      8'h3E: p = kp(4, 2);  // 8
      8'h3D: p = kp(4, 3);  // 7
      8'h36: p = kp(4, 4);  // 6
      8'h4D: p = kp(5, 0);  // P
      8'h44: p = kp(5, 1);  // O
      8'h43: p = kp(5, 2);  // I
      8'h3C: p = kp(5, 3);  // U
      8'h35: p = kp(5, 4);  // Y
      8'h5A: p = kp(6, 0);  // Enter
      8'h4B: p = kp(6, 1);  // L
      8'h42: p = kp(6, 2);  // K
      8'h3B: p = kp(6, 3);  // J
      8'h33: p = kp(6, 4);  // H
      8'h29: p = kp(7, 0);  // Space
      8'h59: p = kp(7, 1);  // RShift -> SS
      8'h14: p = kp(7, 1);  // LCtrl  -> SS
      8'h3A: p = kp(7, 2);  // M
      8'h31: p = kp(7, 3);  // N
      8'h32: p = kp(7, 4);  // B
      default: p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 receiver: synchronises and glitch-filters the keyboard clock, frames
// start/8 data/parity/stop on filtered falling edges, and aborts stalled frames.
module ps2_rx
  import ps2_kbd_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 14000
) (
  input  logic       clk14,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_timeout
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    clk_sync_q;
  logic [1:0]    dat_sync_q;
  logic          filt_clk_q;
  logic [FW-1:0] filt_cnt_q;
  logic          differs;
  logic          flip;
  logic          fall;
  logic          dat_bit;

  rx_state_e     state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          par_ok_q;
  logic [TW-1:0] to_cnt_q;
  logic [7:0]    rx_byte_q;
  logic          rx_valid_q;
  logic          rx_timeout_q;

  // Two-stage synchronisers; lines idle high so reset to 1
  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_dat};
    end
  end

  // The filtered clock follows only after FILTER_LEN consecutive differing samples
  assign differs = (clk_sync_q[1] != filt_clk_q);
  assign flip    = differs && (filt_cnt_q == FW'(FILTER_LEN - 1));
  assign fall    = flip && filt_clk_q;
  assign dat_bit = dat_sync_q[1];

  // Glitch filter on the synchronised clock
  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      filt_clk_q <= 1'b1;
      filt_cnt_q <= '0;
    end else if (!differs) begin
      filt_cnt_q <= '0;
    end else if (flip) begin
      filt_clk_q <= clk_sync_q[1];
      filt_cnt_q <= '0;
    end else begin
      filt_cnt_q <= filt_cnt_q + FW'(1);
    end
  end

  // Frame FSM with parity check, stall timeout and registered outputs
  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RX_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_ok_q     <= 1'b0;
      to_cnt_q     <= '0;
      rx_byte_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_timeout_q <= 1'b0;
    end else begin
      rx_valid_q   <= 1'b0;
      rx_timeout_q <= 1'b0;

      if (fall) begin
        to_cnt_q <= '0;
      end else if (to_cnt_q != TW'(TIMEOUT)) begin
        to_cnt_q <= to_cnt_q + TW'(1);
      end

      case (state_q)
        RX_IDLE: begin
          if (fall && !dat_bit) begin
            state_q   <= RX_DATA;
            bit_cnt_q <= '0;
          end
        end
        RX_DATA: begin
          if (fall) begin
            shift_q   <= {dat_bit, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= RX_PARITY;
          end
        end
        RX_PARITY: begin
          if (fall) begin
            // Odd parity: data ones plus parity bit must be odd
            par_ok_q <= (^shift_q) ^ dat_bit;
            state_q  <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (fall) begin
            if (par_ok_q && dat_bit) begin
              rx_byte_q  <= shift_q;
              rx_valid_q <= 1'b1;
            end
            state_q <= RX_IDLE;
          end
        end
        default: state_q <= RX_IDLE;
      endcase

      // A keyboard that stops clocking mid-frame loses the partial byte
      if ((state_q != RX_IDLE) && !fall && (to_cnt_q == TW'(TIMEOUT - 1))) begin
        state_q      <= RX_IDLE;
        rx_timeout_q <= 1'b1;
      end
    end
  end

  assign rx_byte    = rx_byte_q;
  assign rx_valid   = rx_valid_q;
  assign rx_timeout = rx_timeout_q;

endmodule

// File: rtl/ps2_keyboard_matrix.sv
// Keyboard front end for the port #FE read: decodes PS/2 scancodes into the 8x5
// half-row matrix, overlays composite keys, and drives active-low kd for the
// half-rows selected on A15..A8. Also reports Ctrl+Alt+Del.
module ps2_keyboard_matrix
  import ps2_kbd_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 14000
) (
  input  logic       clk14,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic [7:0] addr_hi,
  output logic [4:0] kd,
  output logic       key_reset
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_timeout;

  ps2_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT    (TIMEOUT)
  ) u_rx (
    .clk14      (clk14),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .rx_timeout (rx_timeout)
  );

  logic [ROWS-1:0][COLS-1:0] mat_q, mat_d;
  logic [ROWS-1:0][COLS-1:0] eff;
  logic [NUM_CMP-1:0]        comp_q, comp_d;
  logic                      ext_q, ext_d;
  logic                      rel_q, rel_d;
  logic                      lctrl_q, lctrl_d;
  logic                      lalt_q, lalt_d;
  logic                      del_q, del_d;
  logic                      key_reset_q;
  logic [COLS-1:0]           kd_q, kd_d;
  key_pos_t                  pos;

  // Scancode decoder: prefix flags, matrix bits, composites and reset-combo flags
  always_comb begin
    mat_d   = mat_q;
    comp_d  = comp_q;
    ext_d   = ext_q;
    rel_d   = rel_q;
    lctrl_d = lctrl_q;
    lalt_d  = lalt_q;
    del_d   = del_q;
    pos     = map_code(rx_byte);

    if (rx_timeout) begin
      ext_d = 1'b0;
      rel_d = 1'b0;
    end

    if (rx_valid) begin
      if (rx_byte == SC_E0) begin
        ext_d = 1'b1;
      end else if (rx_byte == SC_F0) begin
        rel_d = 1'b1;
      end else if ((rx_byte == SC_OVR0) || (rx_byte == SC_OVR1)) begin
        // Keyboard overrun: state is unknown, so release everything
        mat_d   = '0;
        comp_d  = '0;
        ext_d   = 1'b0;
        rel_d   = 1'b0;
        lctrl_d = 1'b0;
        lalt_d  = 1'b0;
        del_d   = 1'b0;
      end else if (rx_byte != SC_BAT) begin
        ext_d = 1'b0;
        rel_d = 1'b0;
        if (ext_q) begin
          case (rx_byte)
            SC_LEFT:  comp_d[CMP_LEFT]  = ~rel_q;
            SC_DOWN:  comp_d[CMP_DOWN]  = ~rel_q;
            SC_UP:    comp_d[CMP_UP]    = ~rel_q;
            SC_RIGHT: comp_d[CMP_RIGHT] = ~rel_q;
            SC_DEL:   del_d             = ~rel_q;
            default:  ;
          endcase
        end else begin
          case (rx_byte)
            SC_BKSP: comp_d[CMP_BKSP] = ~rel_q;
            SC_ESC:  comp_d[CMP_ESC]  = ~rel_q;
            SC_LCTRL: lctrl_d         = ~rel_q;
            SC_LALT:  lalt_d          = ~rel_q;
            default: ;
          endcase
          if (pos.hit) mat_d[pos.row][pos.col] = ~rel_q;
        end
      end
    end
  end

  // Composite keys are ORed on top so releasing one never clears a held key
  always_comb begin
    eff = mat_q;
    if (comp_q[CMP_BKSP]) begin
      eff[ROW_CS][BIT_CS]   = 1'b1;
      eff[ROW_0_6][BIT_K0]  = 1'b1;
    end
    if (comp_q[CMP_ESC]) begin
      eff[ROW_CS][BIT_CS]       = 1'b1;
      eff[ROW_SPACE][BIT_SPACE] = 1'b1;
    end
    if (comp_q[CMP_LEFT]) begin
      eff[ROW_CS][BIT_CS]   = 1'b1;
      eff[ROW_1_5][BIT_K5]  = 1'b1;
    end
    if (comp_q[CMP_DOWN]) begin
      eff[ROW_CS][BIT_CS]   = 1'b1;
      eff[ROW_0_6][BIT_K6]  = 1'b1;
    end
    if (comp_q[CMP_UP]) begin
      eff[ROW_CS][BIT_CS]   = 1'b1;
      eff[ROW_0_6][BIT_K7]  = 1'b1;
    end
    if (comp_q[CMP_RIGHT]) begin
      eff[ROW_CS][BIT_CS]   = 1'b1;
      eff[ROW_0_6][BIT_K8]  = 1'b1;
    end
  end

  // Each kd bit is low if any selected half-row has that key pressed
  for (genvar gi = 0; gi < COLS; gi++) begin : g_kd
    logic [ROWS-1:0] col;
    for (genvar gj = 0; gj < ROWS; gj++) begin : g_row
      assign col[gj] = eff[gj][gi];
    end
    assign kd_d[gi] = ~|(col & ~addr_hi);
  end

  // State and output registers; kd samples the pre-update matrix
  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      mat_q       <= '0;
      comp_q      <= '0;
      ext_q       <= 1'b0;
      rel_q       <= 1'b0;
      lctrl_q     <= 1'b0;
      lalt_q      <= 1'b0;
      del_q       <= 1'b0;
      key_reset_q <= 1'b0;
      kd_q        <= '1;
    end else begin
      mat_q       <= mat_d;
      comp_q      <= comp_d;
      ext_q       <= ext_d;
      rel_q       <= rel_d;
      lctrl_q     <= lctrl_d;
      lalt_q      <= lalt_d;
      del_q       <= del_d;
      key_reset_q <= lctrl_q & lalt_q & del_q;
      kd_q        <= kd_d;
    end
  end

  assign kd        = kd_q;
  assign key_reset = key_reset_q;

endmodule

// File: tb/tb_ps2_keyboard_matrix.sv
// Directed bench for ps2_keyboard_matrix: sends PS/2 frames, pushes the expected
// {key_reset, kd} per step onto a scoreboard and checks it once the output settles.
module tb_ps2_keyboard_matrix;

  localparam int BIT_T = 20;  // clk14 cycles per PS/2 half clock period

  logic       clk14 = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] addr_hi = 8'hFF;
  logic [4:0] kd;
  logic       key_reset;

  int checks = 0;
  int errors = 0;

  logic [5:0] exp_q[$];
  string      tag_q[$];

  always #5 clk14 = ~clk14;

  ps2_keyboard_matrix dut (
    .clk14     (clk14),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .addr_hi   (addr_hi),
    .kd        (kd),
    .key_reset (key_reset)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk14);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    cyc(BIT_T / 2);
    ps2_clk = 1'b0;
    cyc(BIT_T);
    ps2_clk = 1'b1;
    cyc(BIT_T / 2);
  endtask

  task automatic send_byte(input logic [7:0] code, input logic bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(code[i]);
    ps2_bit((~^code) ^ bad_par);
    ps2_bit(1'b1);
    ps2_dat = 1'b1;
    cyc(30);
  endtask

  task automatic push_exp(input logic e_rst, input logic [4:0] e_kd, input string tag);
    exp_q.push_back({e_rst, e_kd});
    tag_q.push_back(tag);
  endtask

  task automatic compare_out();
    logic [5:0] e;
    string      t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert ({key_reset, kd} === e)
    else begin
      errors++;
      $error("FAIL %s: {key_reset,kd} observed %b expected %b", t, {key_reset, kd}, e);
    end
    $display("check %-22s addr_hi=%h {key_reset,kd}=%b", t, addr_hi, {key_reset, kd});
  endtask

  task automatic expect_out(input logic [7:0] a, input logic [4:0] e_kd,
                            input logic e_rst, input string tag);
    push_exp(e_rst, e_kd, tag);
    cyc(1);
    addr_hi = a;
    cyc(2);
    @(negedge clk14);
    compare_out();
  endtask

  initial begin
    // Reset state
    cyc(3);
    @(negedge clk14);
    push_exp(1'b0, 5'b11111, "reset_state");
    compare_out();
    cyc(1);
    rst_n = 1'b1;
    expect_out(8'h00, 5'b11111, 1'b0, "idle_all_rows");

    // A press, one-cycle latency on addr_hi, release
    send_byte(8'h1C, 1'b0);
    expect_out(8'hFF, 5'b11111, 1'b0, "a_unselected");
    cyc(1);
    addr_hi = 8'hFD;
    push_exp(1'b0, 5'b11111, "latency_old");
    @(negedge clk14);
    compare_out();
    push_exp(1'b0, 5'b11110, "latency_new");
    @(negedge clk14);
    compare_out();
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    expect_out(8'hFD, 5'b11111, 1'b0, "a_released");

    // Bad parity dropped; receiver still healthy afterwards
    send_byte(8'h1C, 1'b1);
    expect_out(8'hFD, 5'b11111, 1'b0, "bad_parity_dropped");
    send_byte(8'h1A, 1'b0);
    expect_out(8'hFE, 5'b11101, 1'b0, "z_after_bad");
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1A, 1'b0);

    // Short glitch on ps2_clk with data low must not start a frame
    ps2_dat = 1'b0;
    ps2_clk = 1'b0;
    cyc(3);
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    cyc(40);

    // Cursor left composite, then LShift held across its release
    send_byte(8'hE0, 1'b0);
    send_byte(8'h6B, 1'b0);
    expect_out(8'hFE, 5'b11110, 1'b0, "left_cs");
    expect_out(8'hF7, 5'b01111, 1'b0, "left_5");
    send_byte(8'h12, 1'b0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h6B, 1'b0);
    expect_out(8'hFE, 5'b11110, 1'b0, "lshift_kept");
    expect_out(8'hF7, 5'b11111, 1'b0, "left_released");

    // Backspace composite does not clear a held 0 key on release
    send_byte(8'h66, 1'b0);
    expect_out(8'hEF, 5'b11110, 1'b0, "bksp_0");
    send_byte(8'h45, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h66, 1'b0);
    expect_out(8'hEF, 5'b11110, 1'b0, "zero_kept");
    send_byte(8'hF0, 1'b0);
    send_byte(8'h45, 1'b0);
    expect_out(8'hEF, 5'b11111, 1'b0, "zero_released");

    // Truncated frame, 2 ms silence, then a clean frame
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_dat = 1'b1;
    cyc(28000);
    send_byte(8'h45, 1'b0);
    expect_out(8'hEF, 5'b11110, 1'b0, "after_timeout");
    expect_out(8'h00, 5'b11110, 1'b0, "all_rows_and");

    // Ctrl+Alt+Del
    send_byte(8'h14, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'h71, 1'b0);
    expect_out(8'h7F, 5'b11101, 1'b1, "key_reset_on");
    send_byte(8'hF0, 1'b0);
    send_byte(8'h11, 1'b0);
    expect_out(8'h7F, 5'b11101, 1'b0, "key_reset_off");

    // Overrun clears everything
    send_byte(8'hFF, 1'b0);
    expect_out(8'h00, 5'b11111, 1'b0, "overrun_clear");

    // Reset in the middle of a frame, then a clean frame
    send_byte(8'h1C, 1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    rst_n = 1'b0;
    cyc(2);
    @(negedge clk14);
    push_exp(1'b0, 5'b11111, "mid_frame_reset");
    compare_out();
    cyc(1);
    rst_n = 1'b1;
    expect_out(8'h00, 5'b11111, 1'b0, "cleared_after_reset");
    send_byte(8'h1C, 1'b0);
    expect_out(8'hFD, 5'b11110, 1'b0, "clean_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
